// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcode encodings and the command
// sequencer state encoding.
package alu_pkg;

   localparam int unsigned ALU_DW = 32;

   localparam logic [1:0] ALU_OP_AND = 2'b00;
   localparam logic [1:0] ALU_OP_OR  = 2'b01;
   localparam logic [1:0] ALU_OP_ADD = 2'b10;
   localparam logic [1:0] ALU_OP_SUB = 2'b11;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } seq_state_t;

endpackage

// File: rtl/alu_cmd_seq.sv
// Initiator-side command sequencer for the registered ALU: one command in,
// wait ALU_LAT edges, capture both ALU outputs, one response out.
// Optional result chaining is compiled in with `define ALU_CMD_SEQ_CHAIN_EN.
module alu_cmd_seq
   import alu_pkg::*;
#(
   parameter int unsigned ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ALU_DW-1:0] cmd_a,
   input  logic [ALU_DW-1:0] cmd_b,
   input  logic [1:0]        cmd_op,
   input  logic              cmd_sel,
   input  logic              cmd_chain,
   output logic [ALU_DW-1:0] alu_a,
   output logic [ALU_DW-1:0] alu_b,
   output logic [1:0]        alu_op,
   output logic              alu_mux_sel,
   input  logic [ALU_DW-1:0] alu_res,
   input  logic [ALU_DW-1:0] alu_mux,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ALU_DW-1:0] rsp_alu,
   output logic [ALU_DW-1:0] rsp_mux
);

   if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
      $error("alu_cmd_seq: ALU_LAT must be in 1..15");
   end

   localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

   seq_state_t        state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic [ALU_DW-1:0] alu_a_reg, alu_a_next;
   logic [ALU_DW-1:0] alu_b_reg, alu_b_next;
   logic [1:0]        alu_op_reg, alu_op_next;
   logic              alu_sel_reg, alu_sel_next;
   logic [ALU_DW-1:0] rsp_alu_reg, rsp_alu_next;
   logic [ALU_DW-1:0] rsp_mux_reg, rsp_mux_next;
   logic              cmd_ready_reg, cmd_ready_next;
   logic              rsp_valid_reg, rsp_valid_next;
   logic [ALU_DW-1:0] a_src;

`ifdef ALU_CMD_SEQ_CHAIN_EN
   logic [ALU_DW-1:0] chain_reg, chain_next;
   assign a_src = cmd_chain ? chain_reg : cmd_a;
`else
   logic unused_chain;
   assign unused_chain = cmd_chain;
   assign a_src        = cmd_a;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= INIT;
         cnt_reg       <= '0;
         alu_a_reg     <= '0;
         alu_b_reg     <= '0;
         alu_op_reg    <= ALU_OP_AND;
         alu_sel_reg   <= 1'b0;
         rsp_alu_reg   <= '0;
         rsp_mux_reg   <= '0;
         cmd_ready_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
`ifdef ALU_CMD_SEQ_CHAIN_EN
         chain_reg     <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         alu_a_reg     <= alu_a_next;
         alu_b_reg     <= alu_b_next;
         alu_op_reg    <= alu_op_next;
         alu_sel_reg   <= alu_sel_next;
         rsp_alu_reg   <= rsp_alu_next;
         rsp_mux_reg   <= rsp_mux_next;
         cmd_ready_reg <= cmd_ready_next;
         rsp_valid_reg <= rsp_valid_next;
`ifdef ALU_CMD_SEQ_CHAIN_EN
         chain_reg     <= chain_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      alu_a_next   = alu_a_reg;
      alu_b_next   = alu_b_reg;
      alu_op_next  = alu_op_reg;
      alu_sel_next = alu_sel_reg;
      rsp_alu_next = rsp_alu_reg;
      rsp_mux_next = rsp_mux_reg;
`ifdef ALU_CMD_SEQ_CHAIN_EN
      chain_next   = chain_reg;
`endif
      case (state_reg)
         INIT: state_next = IDLE;
         IDLE: begin
            if (cmd_valid && cmd_ready_reg) begin
               alu_a_next   = a_src;
               alu_b_next   = cmd_b;
               alu_op_next  = cmd_op;
               alu_sel_next = cmd_sel;
               cnt_next     = LAT_LOAD;
               state_next   = WAIT;
            end
         end
         WAIT: begin
            // Counter reaches zero on E(ALU_LAT); capture lands on the edge after.
            if (cnt_reg == 4'd0) begin
               rsp_alu_next = alu_res;
               rsp_mux_next = alu_mux;
`ifdef ALU_CMD_SEQ_CHAIN_EN
               chain_next   = alu_res;
`endif
               state_next   = RESP;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         RESP: begin
            if (rsp_valid_reg && rsp_ready) state_next = IDLE;
         end
         default: state_next = INIT;
      endcase
      // Handshake flags are decoded from the next state so they come straight from flops.
      cmd_ready_next = (state_next == IDLE);
      rsp_valid_next = (state_next == RESP);
   end

   assign cmd_ready   = cmd_ready_reg;
   assign rsp_valid   = rsp_valid_reg;
   assign rsp_alu     = rsp_alu_reg;
   assign rsp_mux     = rsp_mux_reg;
   assign alu_a       = alu_a_reg;
   assign alu_b       = alu_b_reg;
   assign alu_op      = alu_op_reg;
   assign alu_mux_sel = alu_sel_reg;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a behavioural ALU_LAT-stage ALU as load.
// Define ALU_CMD_SEQ_CHAIN_EN to also exercise result chaining.
module tb_alu_cmd_seq;
   import alu_pkg::*;

   localparam int unsigned ALU_LAT = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [ALU_DW-1:0] cmd_a = '0;
   logic [ALU_DW-1:0] cmd_b = '0;
   logic [1:0]        cmd_op = 2'b00;
   logic              cmd_sel = 1'b0;
   logic              cmd_chain = 1'b0;
   logic [ALU_DW-1:0] alu_a, alu_b;
   logic [1:0]        alu_op;
   logic              alu_mux_sel;
   logic [ALU_DW-1:0] alu_res, alu_mux;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [ALU_DW-1:0] rsp_alu, rsp_mux;

   int pass_cnt  = 0;
   int check_cnt = 0;
   bit rsp_seen_in_reset = 1'b0;
   bit watch_rsp = 1'b0;

   always #5 clk = ~clk;

   alu_cmd_seq #(.ALU_LAT(ALU_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mux_sel(alu_mux_sel),
      .alu_res(alu_res), .alu_mux(alu_mux),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_alu(rsp_alu), .rsp_mux(rsp_mux)
   );

   // Behavioural ALU load: result by opcode, mux = sel ? B : result.
   logic [ALU_DW-1:0] res_pipe [ALU_LAT];
   logic [ALU_DW-1:0] mux_pipe [ALU_LAT];
   logic [ALU_DW-1:0] alu_comb;

   always_comb begin
      alu_comb = '0;
      case (alu_op)
         ALU_OP_AND: alu_comb = alu_a & alu_b;
         ALU_OP_OR:  alu_comb = alu_a | alu_b;
         ALU_OP_ADD: alu_comb = alu_a + alu_b;
         default:    alu_comb = alu_a - alu_b;
      endcase
   end

   always_ff @(posedge clk) begin
      res_pipe[0] <= alu_comb;
      mux_pipe[0] <= alu_mux_sel ? alu_b : alu_comb;
      for (int i = 1; i < ALU_LAT; i++) begin
         res_pipe[i] <= res_pipe[i-1];
         mux_pipe[i] <= mux_pipe[i-1];
      end
   end
   assign alu_res = res_pipe[ALU_LAT-1];
   assign alu_mux = mux_pipe[ALU_LAT-1];

   always @(posedge clk) if (watch_rsp && rsp_valid) rsp_seen_in_reset <= 1'b1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a command and returns at #1 after the accepting edge.
   task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input logic sel, input logic chain, output bit ok);
      ok        = 1'b0;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_sel   = sel;
      cmd_chain = chain;
      cmd_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         if (cmd_ready) begin
            tick();
            ok = 1'b1;
            break;
         end
         tick();
      end
      cmd_valid = 1'b0;
      check_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL cmd_accept timeout: cmd_ready never high within 50 cycles");
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL rsp_wait timeout: rsp_valid never high within 50 cycles");
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      else pass_cnt++;
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      check32("reset cmd_ready", 32'(cmd_ready), 32'd0);
      check32("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check32("reset alu_a", alu_a, 32'd0);
      check32("reset alu_b", alu_b, 32'd0);
      check32("reset alu_op", 32'(alu_op), 32'd0);
      check32("reset alu_mux_sel", 32'(alu_mux_sel), 32'd0);
      check32("reset rsp_alu", rsp_alu, 32'd0);
      check32("reset rsp_mux", rsp_mux, 32'd0);
      rst_n = 1'b1;
      check32("cmd_ready before first edge", 32'(cmd_ready), 32'd0);
      tick();
      check32("cmd_ready after first edge", 32'(cmd_ready), 32'd1);
      $display("reset: released, cmd_ready=%0b", cmd_ready);
   endtask

   task automatic test_add_wrap();
      bit ok;
      send_cmd(32'hFFFF_FFFF, 32'd1, ALU_OP_ADD, 1'b0, 1'b0, ok);
      check32("add alu_a driven", alu_a, 32'hFFFF_FFFF);
      check32("add cmd_ready low", 32'(cmd_ready), 32'd0);
      for (int i = 0; i < ALU_LAT; i++) begin
         tick();
         check32("add rsp_valid early", 32'(rsp_valid), 32'd0);
      end
      tick();
      check32("add rsp_valid at E(LAT+1)", 32'(rsp_valid), 32'd1);
      check32("add rsp_alu", rsp_alu, 32'd0);
      check32("add rsp_mux", rsp_mux, 32'd0);
      handshake();
      check32("add rsp_valid cleared", 32'(rsp_valid), 32'd0);
      check32("add cmd_ready after handshake", 32'(cmd_ready), 32'd1);
      $display("add: rsp_alu=0x%08h rsp_mux=0x%08h", rsp_alu, rsp_mux);
   endtask

   task automatic test_sub_sel();
      bit ok;
      send_cmd(32'd5, 32'd7, ALU_OP_SUB, 1'b1, 1'b0, ok);
      wait_rsp(ok);
      check32("sub rsp_alu", rsp_alu, 32'hFFFF_FFFE);
      check32("sub rsp_mux", rsp_mux, 32'd7);
      handshake();
      $display("sub: rsp_alu=0x%08h rsp_mux=0x%08h", rsp_alu, rsp_mux);
   endtask

   task automatic test_backpressure();
      bit ok;
      send_cmd(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_OP_AND, 1'b0, 1'b0, ok);
      wait_rsp(ok);
      // A competing command during RESP must be held off.
      cmd_valid = 1'b1;
      cmd_a     = 32'h1234_5678;
      cmd_b     = 32'h1111_1111;
      cmd_op    = ALU_OP_OR;
      for (int i = 0; i < 10; i++) begin
         check32("bp rsp_alu stable", rsp_alu, 32'hF000_F000);
         check32("bp rsp_mux stable", rsp_mux, 32'hF000_F000);
         check32("bp rsp_valid held", 32'(rsp_valid), 32'd1);
         check32("bp cmd_ready low", 32'(cmd_ready), 32'd0);
         check32("bp alu_a held", alu_a, 32'hF0F0_F0F0);
         tick();
      end
      cmd_valid = 1'b0;
      handshake();
      $display("backpressure: rsp_alu=0x%08h after 10 stalled cycles", rsp_alu);
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      send_cmd(32'hAAAA_0000, 32'h0000_5555, ALU_OP_OR, 1'b0, 1'b0, ok);
      watch_rsp = 1'b1;
      rst_n = 1'b0;
      #1;
      check32("midrst alu_a async", alu_a, 32'd0);
      check32("midrst cmd_ready async", 32'(cmd_ready), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (ALU_LAT + 2) tick();
      watch_rsp = 1'b0;
      check32("midrst rsp_valid never", 32'(rsp_seen_in_reset), 32'd0);
      send_cmd(32'd1, 32'd2, ALU_OP_OR, 1'b0, 1'b0, ok);
      wait_rsp(ok);
      check32("midrst next rsp_alu", rsp_alu, 32'd3);
      handshake();
      $display("reset_mid_op: next rsp_alu=0x%08h", rsp_alu);
   endtask

   task automatic test_back_to_back();
      bit ok;
      int cyc;
      rsp_ready = 1'b1;
      send_cmd(32'd100, 32'd23, ALU_OP_ADD, 1'b1, 1'b0, ok);
      cyc = 0;
      while (!cmd_ready && cyc < 50) begin
         tick();
         cyc++;
      end
      check32("b2b edges to next cmd_ready", 32'(cyc), 32'(ALU_LAT + 2));
      check32("b2b rsp_alu", rsp_alu, 32'd123);
      check32("b2b rsp_mux", rsp_mux, 32'd23);
      send_cmd(32'h8000_0000, 32'h8000_0000, ALU_OP_ADD, 1'b0, 1'b0, ok);
      repeat (ALU_LAT + 1) tick();
      check32("b2b second rsp_alu", rsp_alu, 32'd0);
      rsp_ready = 1'b0;
      tick();
      $display("back_to_back: occupancy edges=%0d", cyc + 1);
   endtask

`ifdef ALU_CMD_SEQ_CHAIN_EN
   task automatic test_chain();
      bit ok;
      send_cmd(32'd3, 32'd4, ALU_OP_ADD, 1'b0, 1'b0, ok);
      wait_rsp(ok);
      check32("chain first rsp_alu", rsp_alu, 32'd7);
      handshake();
      send_cmd(32'hDEAD_BEEF, 32'd10, ALU_OP_ADD, 1'b0, 1'b1, ok);
      check32("chain alu_a from chain reg", alu_a, 32'd7);
      wait_rsp(ok);
      check32("chain second rsp_alu", rsp_alu, 32'd17);
      handshake();
      $display("chain: second rsp_alu=%0d", rsp_alu);
   endtask
`endif

   initial begin
      test_reset();
      test_add_wrap();
      test_sub_sel();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
`ifdef ALU_CMD_SEQ_CHAIN_EN
      test_chain();
`endif
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
